// File: rtl/axil_slv_regfile.sv
// axil_slv_regfile: AXI4-Lite register file; last register is a read-only ID.
// Define AXIL_SLV_REGFILE_SLVERR_EN to answer SLVERR on out-of-range or ID-register writes.
module axil_slv_regfile #(
  parameter int          ADDR_W = 8,
  parameter int          NREGS  = 16,
  parameter logic [31:0] ID_VAL = 32'hA5C0_0001
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready
);
  localparam int IW = $clog2(NREGS);
  localparam logic [1:0] OKAY = 2'b00;
`ifdef AXIL_SLV_REGFILE_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_t;
  wstate_t        state_q, state_d;
  logic [31:0]    regs_q [NREGS];
  logic           rdy_q, aw_held_q, w_held_q, aw_ok_q, rvalid_q;
  logic [IW-1:0]  aw_idx_q;
  logic [31:0]    wdata_q, rdata_q;
  logic [3:0]     wstrb_q;
  logic [1:0]     bresp_q, rresp_q;
  logic           aw_fire, w_fire, b_fire, ar_fire, r_fire, commit, wr_ok, ar_ok;
  logic [IW-1:0]  ar_idx;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W+1)'(NREGS*4);
  endfunction

  assign s_bvalid  = (state_q == W_RESP);
  assign s_awready = rdy_q & ~aw_held_q & ~s_bvalid;
  assign s_wready  = rdy_q & ~w_held_q & ~s_bvalid;
  assign s_arready = rdy_q & ~rvalid_q;
  assign s_bresp   = bresp_q;
  assign s_rvalid  = rvalid_q;
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;
  assign aw_fire   = s_awvalid & s_awready;
  assign w_fire    = s_wvalid & s_wready;
  assign b_fire    = s_bvalid & s_bready;
  assign ar_fire   = s_arvalid & s_arready;
  assign r_fire    = rvalid_q & s_rready;
  assign commit    = (state_q == W_WAIT) & aw_held_q & w_held_q;
  assign wr_ok     = aw_ok_q & (aw_idx_q != IW'(NREGS-1));
  assign ar_idx    = s_araddr[IW+1:2];
  assign ar_ok     = in_range(s_araddr);

  always_comb begin
    state_d = (state_q == W_IDLE && (aw_fire || w_fire)) ? W_WAIT :
              commit ? W_RESP :
              b_fire ? W_IDLE : state_q;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q   <= W_IDLE;
      rdy_q     <= 1'b0;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_ok_q   <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= OKAY;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= (i == NREGS-1) ? ID_VAL : 32'h0;
    end else begin
      rdy_q   <= 1'b1;
      state_q <= state_d;
      if (aw_fire) begin
        aw_held_q <= 1'b1;
        aw_idx_q  <= s_awaddr[IW+1:2];
        aw_ok_q   <= in_range(s_awaddr);
      end else if (b_fire) aw_held_q <= 1'b0;
      if (w_fire) begin
        w_held_q <= 1'b1;
        wdata_q  <= s_wdata;
        wstrb_q  <= s_wstrb;
      end else if (b_fire) w_held_q <= 1'b0;
      if (commit) begin
        bresp_q <= wr_ok ? OKAY : ERR;
        if (wr_ok)
          for (int b = 0; b < 4; b++)
            if (wstrb_q[b]) regs_q[aw_idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
      // regs_q is sampled before any same-edge commit, so a racing read sees the old value
      if (ar_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= ar_ok ? regs_q[ar_idx] : 32'h0;
        rresp_q  <= ar_ok ? OKAY : ERR;
      end else if (r_fire) rvalid_q <= 1'b0;
    end
  end
endmodule

// File: doc/axil_slv_regfile.md
AXIL_SLV_REGFILE -- requirements
Module: axil_slv_regfile

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, byte address width of AW/AR channels.
REQ-002 SHALL have parameter NREGS, default 16, number of 32-bit registers (power of 2, NREGS*4 <= 2**ADDR_W).
REQ-003 SHALL have parameter ID_VAL, default 32'hA5C0_0001, constant returned by the last register (index NREGS-1).
REQ-004 Clocking and reset are fixed: one clock `aclk`; reset `aresetn` is synchronous and active-low.
REQ-005 Ports:
  aclk  in  1  clock, all logic on rising edge
  aresetn  in  1  synchronous active-low reset
  s_awaddr  in  ADDR_W  write address
  s_awvalid / s_awready  in / out  1  write-address handshake
  s_wdata  in  32  write data
  s_wstrb  in  4  byte enables
  s_wvalid / s_wready  in / out  1  write-data handshake
  s_bresp  out  2  write response
  s_bvalid / s_bready  out / in  1  write-response handshake
  s_araddr  in  ADDR_W  read address
  s_arvalid / s_arready  in / out  1  read-address handshake
  s_rdata  out  32  read data
  s_rresp  out  2  read response
  s_rvalid / s_rready  out / in  1  read-data handshake

Function
REQ-006 Protocol SHALL be AXI4-Lite responder; a transfer occurs on any rising edge where valid and ready are both high.
REQ-007 Register index SHALL be addr[log2(NREGS)+1:2]; addr[1:0] ignored; address in range iff addr < NREGS*4.
REQ-008 s_awready SHALL be high iff no AW is held and s_bvalid is low; s_wready SHALL be high iff no W is held and s_bvalid is low.
REQ-009 AW and W SHALL be accepted independently in either order or the same cycle; each is held until its partner arrives.
REQ-010 Write SHALL commit on the first edge after both AW and W are held: byte n of register updated iff s_wstrb[n]=1; s_bvalid asserts on that edge.
REQ-011 s_bvalid SHALL stay high with stable s_bresp until s_bready; the holds clear on the B handshake; earliest next AW/W acceptance is the cycle after it.
REQ-012 Write write-path state: W_IDLE -> (AW and/or W held) W_WAIT -> (both held) W_RESP -> (B handshake) W_IDLE.
REQ-013 Writes to register NREGS-1 SHALL be discarded; it always reads ID_VAL.
REQ-014 s_arready SHALL be high iff s_rvalid is low; on AR handshake s_rdata/s_rresp SHALL be registered and s_rvalid asserted the next edge (1-cycle latency).
REQ-015 s_rvalid, s_rdata, s_rresp SHALL remain stable until R handshake; s_rvalid clears on it.
REQ-016 Simultaneous write commit and AR acceptance to the same index: read SHALL return the pre-write value.
REQ-017 Read and write paths SHALL operate concurrently with no mutual stall.
REQ-018 In-range accesses SHALL respond OKAY (2'b00).

Reset
REQ-019 While aresetn=0 at a rising edge: all registers 0 (except index NREGS-1 = ID_VAL), holds cleared, write FSM W_IDLE.
REQ-020 Reset values: s_bvalid=0, s_rvalid=0, s_bresp=2'b00, s_rresp=2'b00, s_rdata=0; s_awready, s_wready, s_arready=0 during reset, 1 on the first edge after release.
REQ-021 Reset mid-transaction SHALL abort it with no register update and no response emitted afterward.

Configuration
REQ-022 Macro AXIL_SLV_REGFILE_SLVERR_EN: when defined, out-of-range accesses and writes to index NREGS-1 SHALL respond SLVERR (2'b10), out-of-range reads return rdata 0.
REQ-023 When AXIL_SLV_REGFILE_SLVERR_EN is undefined, those accesses SHALL respond OKAY, writes discarded, out-of-range reads return 0.

Verification
REQ-024 AW 0x08 and W 0xDEADBEEF strb 4'hF same cycle, bready=1 -> bvalid 1 cycle after acceptance, bresp 00; read 0x08 -> rdata 0xDEADBEEF one cycle after AR.
REQ-025 W 0x11223344 strb 4'b0101 three cycles before AW 0x04 (reg was 0) -> reg 1 reads 0x00220044; awready low while bvalid pending.
REQ-026 bready held low 5 cycles -> bvalid, bresp stable all 5 cycles; awready/wready low until cycle after B handshake.
REQ-027 Read 0x3C -> rdata 0xA5C00001; write 0 there then read -> still 0xA5C00001; with SLVERR_EN bresp 10, without 00.
REQ-028 Read 0x80 with SLVERR_EN -> rresp 10, rdata 0; without -> rresp 00, rdata 0; rready low 4 cycles -> rvalid/rdata stable.
REQ-029 aresetn pulled low while AW held and W not yet sent -> no bvalid ever; register unchanged; all outputs at REQ-020 values.
